// File: rtl/sram_arbiter.sv
// sram_arbiter: two-requester round-robin front end for a single-port
// synchronous SRAM macro. Grants wait for a synchronised PLL lock, each
// transaction strobes the macro for exactly one cycle, and reads return a
// one-cycle response pulse on the requester that issued them.

// Per-requester response register: captures read data and emits the pulse.
module sram_arbiter_rsp_lane #(
   parameter int DATA_W = 16
) (
   input  logic              clock,
   input  logic              reset_n,
   input  logic              fire,
   input  logic [DATA_W-1:0] rd_data,
   output logic              rsp_valid,
   output logic [DATA_W-1:0] rsp_rdata
);
   // Pulse one cycle after capture; data holds until the next capture.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         rsp_valid <= 1'b0;
         rsp_rdata <= '0;
      end else begin
         rsp_valid <= fire;
         if (fire) rsp_rdata <= rd_data;
      end
   end
endmodule

module sram_arbiter #(
   parameter int ADDR_W       = 10,
   parameter int DATA_W       = 16,
   parameter int READ_LATENCY = 1
) (
   input  logic              clock,
   input  logic              reset_n,
   input  logic              pll_lock,
   input  logic              req0_valid,
   input  logic              req0_write,
   input  logic [ADDR_W-1:0] req0_addr,
   input  logic [DATA_W-1:0] req0_wdata,
   output logic              req0_ready,
   input  logic              req1_valid,
   input  logic              req1_write,
   input  logic [ADDR_W-1:0] req1_addr,
   input  logic [DATA_W-1:0] req1_wdata,
   output logic              req1_ready,
   output logic              rsp0_valid,
   output logic [DATA_W-1:0] rsp0_rdata,
   output logic              rsp1_valid,
   output logic [DATA_W-1:0] rsp1_rdata,
   output logic              mem_chip_en,
   output logic              mem_wr_en,
   output logic              mem_rd_en,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wr_data,
   input  logic [DATA_W-1:0] mem_rd_data,
   output logic              busy
);
   localparam int NUM_REQ = 2;
   localparam logic [2:0] CNT_INIT = 3'(READ_LATENCY - 1);

   typedef enum logic [1:0] {ST_IDLE, ST_ISSUE, ST_WAIT} state_t;

   state_t state, state_nxt;

   logic lock_s1, lock_q;
   logic last_grant, winner, gnt_q, wr_q, accept, rsp_fire;
   logic [2:0] cnt;

   logic [NUM_REQ-1:0]             req_valid, req_write, ready, rsp_valid;
   logic [NUM_REQ-1:0][ADDR_W-1:0] req_addr;
   logic [NUM_REQ-1:0][DATA_W-1:0] req_wdata, rsp_rdata;

   assign req_valid = {req1_valid, req0_valid};
   assign req_write = {req1_write, req0_write};
   assign req_addr  = {req1_addr,  req0_addr};
   assign req_wdata = {req1_wdata, req0_wdata};

   assign req0_ready = ready[0];
   assign req1_ready = ready[1];
   assign rsp0_valid = rsp_valid[0];
   assign rsp1_valid = rsp_valid[1];
   assign rsp0_rdata = rsp_rdata[0];
   assign rsp1_rdata = rsp_rdata[1];

   assign busy     = (state != ST_IDLE);
   assign accept   = |ready;
   assign rsp_fire = (state == ST_WAIT) && (cnt == 3'd0);

   // Two-flop synchroniser for the asynchronous PLL lock.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         lock_s1 <= 1'b0;
         lock_q  <= 1'b0;
      end else begin
         lock_s1 <= pll_lock;
         lock_q  <= lock_s1;
      end
   end

   // Round-robin pick: a lone requester wins; on a tie, the one not granted last.
   always_comb begin
      if (req_valid == 2'b11) winner = ~last_grant;
      else                    winner = req_valid[1];
   end

   // State register.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) state <= ST_IDLE;
      else          state <= state_nxt;
   end

   // Next state, grants and SRAM strobes; strobes exist only in ISSUE.
   always_comb begin
      state_nxt   = state;
      ready       = '0;
      mem_chip_en = 1'b0;
      mem_wr_en   = 1'b0;
      mem_rd_en   = 1'b0;
      case (state)
         ST_IDLE: begin
            if (lock_q && (|req_valid)) begin
               ready[winner] = 1'b1;
               state_nxt     = ST_ISSUE;
            end
         end
         ST_ISSUE: begin
            mem_chip_en = 1'b1;
            mem_wr_en   = wr_q;
            mem_rd_en   = !wr_q;
            state_nxt   = wr_q ? ST_IDLE : ST_WAIT;
         end
         ST_WAIT: begin
            if (cnt == 3'd0) state_nxt = ST_IDLE;
         end
         default: state_nxt = ST_IDLE;
      endcase
   end

   // Capture the winner's request; mem_addr/mem_wr_data double as the
   // payload registers so they hold the last issued values afterwards.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         last_grant  <= 1'b1;
         gnt_q       <= 1'b0;
         wr_q        <= 1'b0;
         mem_addr    <= '0;
         mem_wr_data <= '0;
      end else if (accept) begin
         last_grant  <= winner;
         gnt_q       <= winner;
         wr_q        <= req_write[winner];
         mem_addr    <= req_addr[winner];
         mem_wr_data <= req_wdata[winner];
      end
   end

   // Read latency counter: loaded leaving ISSUE, counts down through WAIT.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n)                               cnt <= '0;
      else if (state == ST_ISSUE)                 cnt <= CNT_INIT;
      else if (state == ST_WAIT && cnt != 3'd0)   cnt <= cnt - 3'd1;
   end

   for (genvar g = 0; g < NUM_REQ; g++) begin : g_rsp
      sram_arbiter_rsp_lane #(.DATA_W(DATA_W)) u_lane (
         .clock     (clock),
         .reset_n   (reset_n),
         .fire      (rsp_fire && (gnt_q == 1'(g))),
         .rd_data   (mem_rd_data),
         .rsp_valid (rsp_valid[g]),
         .rsp_rdata (rsp_rdata[g])
      );
   end
endmodule

// File: doc/sram_arbiter.md
# sram_arbiter

Two-port round-robin arbiter and sequencer for the single-port 16x1024 synchronous SRAM macro (`MemGen_16_10`) inside the memory subsystem. It serialises read/write requests from two requesters onto the macro's `chip_en`/`wr_en`/`rd_en`/`addr`/`wr_data` pins and returns read data with a one-cycle response pulse. It grants nothing until the PLL `LOCK` output, synchronised internally, is high.

## Interface
- `ADDR_W`, 10, SRAM address width
- `DATA_W`, 16, SRAM data width
- `READ_LATENCY`, 1, cycles from the sampling edge of `rd_en` to valid `mem_rd_data`; legal range 1–4

- `clock` in 1 — single clock; all logic is on the rising edge
- `reset_n` in 1 — asynchronous, active-low reset
- `pll_lock` in 1 — PLL `LOCK`; asynchronous to `clock`
- `reqN_valid` in 1 (N=0,1) — request present
- `reqN_write` in 1 — 1 = write, 0 = read
- `reqN_addr` in ADDR_W — word address
- `reqN_wdata` in DATA_W — write data
- `reqN_ready` out 1 — request accepted this cycle
- `rspN_valid` out 1 — one-cycle read-response pulse
- `rspN_rdata` out DATA_W — read data; valid while `rspN_valid` is high
- `mem_chip_en` out 1 — to SRAM `chip_en`
- `mem_wr_en` out 1 — to SRAM `wr_en`
- `mem_rd_en` out 1 — to SRAM `rd_en`
- `mem_addr` out ADDR_W — to SRAM `addr`
- `mem_wr_data` out DATA_W — to SRAM `wr_data`
- `mem_rd_data` in DATA_W — from SRAM `rd_data`
- `busy` out 1 — high whenever the state is not IDLE

## Operation
- **PLL lock synchroniser.** `pll_lock` passes through a 2-flop synchroniser; its output is `lock_q`. No grant is issued while `lock_q` = 0.
- **States.**
  - IDLE → ISSUE on an accept.
  - ISSUE → IDLE for a write.
  - ISSUE → WAIT for a read.
  - WAIT → IDLE after READ_LATENCY cycles.
- **Arbitration.** Combinational, and only in IDLE with `lock_q` = 1.
  - If exactly one `reqN_valid` is high, that requester wins.
  - If both are high, the requester that is not `last_grant` wins.
  - `reqN_ready` = IDLE & `lock_q` & winner==N.
  - Accept = `reqN_valid` & `reqN_ready`.
  - `last_grant` updates on each accept; its reset value is 1, so requester 0 wins the first tie.
- **Requester rules.** A requester holds `valid` and its payload stable until `ready`. Dropping `valid` before `ready` is legal and cancels the request.
- **On accept.** Register the winner's id, write flag, addr and wdata.
- **ISSUE (exactly one cycle).**
  - `mem_chip_en` = 1.
  - `mem_wr_en` = write flag; `mem_rd_en` = !write flag.
  - `mem_addr` and `mem_wr_data` are driven from the registers.
- **Outside ISSUE.** `mem_chip_en`, `mem_wr_en` and `mem_rd_en` are 0. `mem_addr` and `mem_wr_data` hold their last issued values.
- **WAIT.** A down-counter is loaded with READ_LATENCY−1 on entry. When the count is 0, `mem_rd_data` is captured into `rspN_rdata` of the granted requester, `rspN_valid` pulses on the next cycle, and the state returns to IDLE.
- **Writes** produce no response.
- **Lock loss.** If `lock_q` falls mid-transaction, the transaction still completes (the SRAM is unaffected). New grants wait for `lock_q` = 1.
- **`rspN_rdata`** holds its value between pulses.
- **Reset.** Applies immediately in any state and aborts any transaction in flight; no response is emitted for it.
  - State = IDLE.
  - All outputs = 0, including `rspN_rdata`, `mem_addr`, `mem_wr_data` and `busy`.
  - `last_grant` = 1.
  - Synchroniser flops = 0.

## Timing
- **Accept to SRAM.** Accept at cycle T → SRAM strobes high in T+1 → the SRAM samples at the end of T+1.
- **Read.** `mem_rd_data` is valid in T+1+READ_LATENCY; `rspN_valid` is high in T+2+READ_LATENCY. Default end-to-end read latency is 3 cycles.
- **IDLE re-entry.** Write: IDLE again at T+2, so the next accept is possible in T+2 (peak 1 write / 2 cycles). Read: IDLE at T+2+READ_LATENCY, concurrent with the `rspN_valid` pulse (1 read / (2+READ_LATENCY) cycles).
- **`reqN_ready`** is combinational from state, `lock_q` and the valids. It is never high for both requesters in the same cycle, and never outside IDLE.
- **Lock-up delay.** `pll_lock` rising to the first possible `ready` takes 2–3 cycles.
- **Back-to-back and simultaneous requests.** With both requesters continuously valid, grants alternate 0,1,0,1.
- **Fairness.** No requester waits more than one transaction of the other.

## Test plan
- **Lock gating.** Hold `pll_lock`=0 with `req0_valid`=1 → `req0_ready` stays 0. Raise `pll_lock` → `req0_ready`=1 within 3 cycles.
- **Write then read, same address.** Write 0xA5C3 to addr 0x3FF via req0 → one cycle of `mem_chip_en`=1, `mem_wr_en`=1, `mem_addr`=0x3FF. Then read 0x3FF via req1 → `rsp1_valid` exactly 3 cycles after the accept with `rsp1_rdata`=0xA5C3, and `rsp0_valid` stays 0.
- **Contention.** Both requesters continuously valid for 8 writes → grant order 0,1,0,1,…; accepts every 2 cycles; `busy` toggles 1,0.
- **READ_LATENCY=3.** Read → `rsp_valid` 5 cycles after the accept; `busy` high for 4 cycles.
- **Lock loss mid-read.** Drop `pll_lock` in the ISSUE cycle of a read → the read response still arrives. No further `ready` until lock is reasserted and synchronised.
- **Reset mid-read.** Assert `reset_n`=0 in WAIT → all outputs 0 asynchronously. After release, no `rsp` pulse for the aborted read, and requester 0 wins the first tie.
